// File: rtl/sri_to_axilite_pkg.sv
// Shared types and AXI response helpers for the SRI to AXI4-Lite master bridge.
package sri_to_axilite_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP
  } sri_axi_state_t;

  function automatic logic resp_is_error(input logic [1:0] resp);
    logic err;
    err = 1'b1;
    case (resp)
      AXI_RESP_OKAY, AXI_RESP_EXOKAY:   err = 1'b0;
      AXI_RESP_SLVERR, AXI_RESP_DECERR: err = 1'b1;
      default:                          err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/sri_to_axilite.sv
// SRI target to AXI4-Lite master bridge: one outstanding read or write at a time,
// response returned as a single-cycle sri_rvalid_o pulse.
module sri_to_axilite
  import sri_to_axilite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int SRI_ADDR_WIDTH = 6,
  parameter int SRI_DATA_WIDTH = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_BASE_ADDR = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          sri_en_i,
  output logic                          sri_ready_o,
  input  logic                          sri_we_i,
  input  logic [SRI_ADDR_WIDTH-1:0]     sri_addr_i,
  input  logic [SRI_DATA_WIDTH-1:0]     sri_wdata_i,
  input  logic [SRI_DATA_WIDTH/8-1:0]   sri_be_i,
  output logic                          sri_rvalid_o,
  output logic [SRI_DATA_WIDTH-1:0]     sri_rdata_o,
  output logic                          sri_error_o,
  output logic [AXI_ADDR_WIDTH-1:0]     m_awaddr_o,
  output logic                          m_awvalid_o,
  input  logic                          m_awready_i,
  output logic [AXI_DATA_WIDTH-1:0]     m_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_wstrb_o,
  output logic                          m_wvalid_o,
  input  logic                          m_wready_i,
  input  logic [1:0]                    m_bresp_i,
  input  logic                          m_bvalid_i,
  output logic                          m_bready_o,
  output logic [AXI_ADDR_WIDTH-1:0]     m_araddr_o,
  output logic                          m_arvalid_o,
  input  logic                          m_arready_i,
  input  logic [AXI_DATA_WIDTH-1:0]     m_rdata_i,
  input  logic [1:0]                    m_rresp_i,
  input  logic                          m_rvalid_i,
  output logic                          m_rready_o,
  output sri_axi_state_t                state_o
);

  if (AXI_DATA_WIDTH != SRI_DATA_WIDTH) begin : g_width_check
    $error("AXI_DATA_WIDTH must equal SRI_DATA_WIDTH");
  end
  if (SRI_ADDR_WIDTH > AXI_ADDR_WIDTH) begin : g_addr_check
    $error("SRI_ADDR_WIDTH must not exceed AXI_ADDR_WIDTH");
  end
  if (AXI_BASE_ADDR[SRI_ADDR_WIDTH-1:0] != '0) begin : g_base_check
    $error("AXI_BASE_ADDR low SRI_ADDR_WIDTH bits must be zero");
  end

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid and ready are both high; valid, once raised, holds with stable payload
  // until that edge and drops in the following cycle.
  sri_axi_state_t              state;
  logic                        aw_done;
  logic                        w_done;
  logic [AXI_ADDR_WIDTH-1:0]   addr_ext;
  logic                        aw_fire;
  logic                        w_fire;

  always_comb begin
    addr_ext = '0;
    addr_ext[SRI_ADDR_WIDTH-1:0] = sri_addr_i;
    addr_ext = addr_ext | AXI_BASE_ADDR;
  end

  assign aw_fire     = m_awvalid_o && m_awready_i;
  assign w_fire      = m_wvalid_o && m_wready_i;
  assign sri_ready_o = (state == IDLE);
  assign state_o     = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      m_awaddr_o   <= '0;
      m_awvalid_o  <= 1'b0;
      m_wdata_o    <= '0;
      m_wstrb_o    <= '0;
      m_wvalid_o   <= 1'b0;
      m_bready_o   <= 1'b0;
      m_araddr_o   <= '0;
      m_arvalid_o  <= 1'b0;
      m_rready_o   <= 1'b0;
      sri_rvalid_o <= 1'b0;
      sri_rdata_o  <= '0;
      sri_error_o  <= 1'b0;
    end else begin
      sri_rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (sri_en_i) begin
            if (sri_we_i) begin
              m_awaddr_o  <= addr_ext;
              m_wdata_o   <= sri_wdata_i;
              m_wstrb_o   <= sri_be_i;
              m_awvalid_o <= 1'b1;
              m_wvalid_o  <= 1'b1;
              aw_done     <= 1'b0;
              w_done      <= 1'b0;
              state       <= WR_REQ;
            end else begin
              m_araddr_o  <= addr_ext;
              m_arvalid_o <= 1'b1;
              state       <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          // AW and W retire independently; the response phase waits for both.
          if (aw_fire) begin
            m_awvalid_o <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_fire) begin
            m_wvalid_o <= 1'b0;
            w_done     <= 1'b1;
          end
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            m_bready_o <= 1'b1;
            state      <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_bvalid_i) begin
            m_bready_o   <= 1'b0;
            sri_rvalid_o <= 1'b1;
            sri_rdata_o  <= '0;
            sri_error_o  <= resp_is_error(m_bresp_i);
            state        <= IDLE;
          end
        end
        RD_REQ: begin
          if (m_arready_i) begin
            m_arvalid_o <= 1'b0;
            m_rready_o  <= 1'b1;
            state       <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (m_rvalid_i) begin
            m_rready_o   <= 1'b0;
            sri_rvalid_o <= 1'b1;
            sri_rdata_o  <= m_rdata_i;
            sri_error_o  <= resp_is_error(m_rresp_i);
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sri_to_axilite.sv
// Bench for sri_to_axilite: directed and random SRI requests against a bench-side
// AXI-lite slave memory, checked against a word-level memory model.
module tb_sri_to_axilite;
  import sri_to_axilite_pkg::*;

  localparam int AW  = 20;
  localparam int DW  = 64;
  localparam int SAW = 6;
  localparam int BW  = DW / 8;
  localparam logic [AW-1:0] BASE = '0;

  logic clk = 1'b0;
  logic rst;
  logic sri_en, sri_ready_o, sri_we;
  logic [SAW-1:0] sri_addr;
  logic [DW-1:0] sri_wdata;
  logic [BW-1:0] sri_be;
  logic sri_rvalid_o, sri_error_o;
  logic [DW-1:0] sri_rdata_o;
  logic [AW-1:0] m_awaddr_o, m_araddr_o;
  logic m_awvalid_o, m_awready, m_wvalid_o, m_wready, m_bvalid, m_bready_o;
  logic m_arvalid_o, m_arready, m_rvalid, m_rready_o;
  logic [DW-1:0] m_wdata_o, m_rdata;
  logic [BW-1:0] m_wstrb_o;
  logic [1:0] m_bresp, m_rresp;
  sri_axi_state_t state_dbg;

  always #5 clk = ~clk;

  sri_to_axilite #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .SRI_ADDR_WIDTH(SAW),
    .SRI_DATA_WIDTH(DW), .AXI_BASE_ADDR(BASE)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .sri_en_i(sri_en), .sri_ready_o(sri_ready_o), .sri_we_i(sri_we),
    .sri_addr_i(sri_addr), .sri_wdata_i(sri_wdata), .sri_be_i(sri_be),
    .sri_rvalid_o(sri_rvalid_o), .sri_rdata_o(sri_rdata_o), .sri_error_o(sri_error_o),
    .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready),
    .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready_o),
    .m_araddr_o(m_araddr_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready),
    .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rvalid_i(m_rvalid), .m_rready_o(m_rready_o),
    .state_o(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model_mem [64];
  logic [DW-1:0] slave_mem [logic [AW-1:0]];
  logic [DW-1:0] last_rdata = '0;
  logic          last_err   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic model_err(input logic [1:0] resp);
    return (resp == 2'b10) || (resp == 2'b11);
  endfunction

  task automatic slave_idle();
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0;
  endtask

  // Quiet cycles: no response, nothing on AXI, response outputs hold.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      checkb("idle_rvalid", sri_rvalid_o, 1'b0);
      checkb("idle_ready", sri_ready_o, 1'b1);
      check("idle_rdata_hold", sri_rdata_o, last_rdata);
      checkb("idle_error_hold", sri_error_o, last_err);
      checkb("idle_axi_quiet", m_awvalid_o | m_wvalid_o | m_arvalid_o | m_bready_o | m_rready_o, 1'b0);
    end
  endtask

  // Issue one request at the current negedge and play the AXI slave. Delays:
  // write d0=aw, d1=w, d2=b; read d0=ar, d1=r. Returns at the response-pulse negedge.
  task automatic txn(input bit we, input logic [SAW-1:0] addr, input logic [DW-1:0] wd,
                     input logic [BW-1:0] be, input int d0, input int d1, input int d2,
                     input logic [1:0] resp, input bit poke, input int abort_k);
    logic [AW-1:0] exp_addr, cap_awaddr, cap_araddr;
    logic [DW-1:0] cap_wdata, exp_rdata;
    logic [BW-1:0] cap_wstrb;
    logic exp_err;
    int exp_k, aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, done;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; done = 0;
    cap_awaddr = '0; cap_araddr = '0; cap_wdata = '0; cap_wstrb = '0;
    exp_addr = BASE | AW'(addr);
    exp_err  = model_err(resp);
    exp_k    = we ? 3 + ((d0 > d1) ? d0 : d1) + d2 : 3 + d0 + d1;
    exp_rdata = we ? '0 : model_mem[addr];
    checkb("ready_at_request", sri_ready_o, 1'b1);
    sri_en = 1'b1; sri_we = we; sri_addr = addr; sri_wdata = wd; sri_be = be;
    for (int k = 1; k <= 300 && !done; k++) begin
      @(negedge clk);
      if (k == 1) begin
        sri_en = 1'b0; sri_we = 1'($urandom); sri_addr = SAW'($urandom);
        sri_wdata = {$urandom, $urandom}; sri_be = BW'($urandom);
      end
      if (k == abort_k) begin
        rst = 1'b1;
        #1;
        checkb("rst_axi_quiet", m_awvalid_o | m_wvalid_o | m_arvalid_o | m_bready_o | m_rready_o, 1'b0);
        checkb("rst_no_rvalid", sri_rvalid_o, 1'b0);
        checkb("rst_ready", sri_ready_o, 1'b1);
        slave_idle();
        sri_en = 1'b0;
        done = 1;
      end else if (sri_rvalid_o) begin
        check("pulse_cycle", 64'(k), 64'(exp_k));
        checkb("resp_error", sri_error_o, exp_err);
        check("resp_rdata", sri_rdata_o, exp_rdata);
        last_rdata = exp_rdata;
        last_err   = exp_err;
        if (we && !exp_err) model_mem[addr] = merge(model_mem[addr], wd, be);
        slave_idle();
        sri_en = 1'b0;
        done = 1;
      end else begin
        checkb("busy_not_ready", sri_ready_o, 1'b0);
        if (we) begin
          checkb("awvalid", m_awvalid_o, !aw_hs);
          checkb("wvalid", m_wvalid_o, !w_hs);
          checkb("bready", m_bready_o, aw_hs && w_hs && !b_hs);
          checkb("wr_no_read", m_arvalid_o | m_rready_o, 1'b0);
          if (m_awvalid_o) check("awaddr", 64'(m_awaddr_o), 64'(exp_addr));
          if (m_wvalid_o) begin
            check("wdata", m_wdata_o, wd);
            check("wstrb", 64'(m_wstrb_o), 64'(be));
          end
          m_awready = m_awvalid_o && (aw_wait >= d0);
          if (m_awvalid_o) aw_wait++;
          if (m_awvalid_o && m_awready) begin aw_hs = 1; cap_awaddr = m_awaddr_o; end
          m_wready = m_wvalid_o && (w_wait >= d1);
          if (m_wvalid_o) w_wait++;
          if (m_wvalid_o && m_wready) begin w_hs = 1; cap_wdata = m_wdata_o; cap_wstrb = m_wstrb_o; end
          m_bresp  = resp;
          m_bvalid = m_bready_o && (b_wait >= d2);
          if (m_bready_o) b_wait++;
          if (m_bready_o && m_bvalid) begin
            b_hs = 1;
            if (!exp_err)
              slave_mem[cap_awaddr] = merge(slave_mem.exists(cap_awaddr) ? slave_mem[cap_awaddr] : '0,
                                            cap_wdata, cap_wstrb);
          end
        end else begin
          checkb("arvalid", m_arvalid_o, !ar_hs);
          checkb("rready", m_rready_o, ar_hs && !r_hs);
          checkb("rd_no_write", m_awvalid_o | m_wvalid_o | m_bready_o, 1'b0);
          if (m_arvalid_o) check("araddr", 64'(m_araddr_o), 64'(exp_addr));
          m_arready = m_arvalid_o && (ar_wait >= d0);
          if (m_arvalid_o) ar_wait++;
          if (m_arvalid_o && m_arready) begin ar_hs = 1; cap_araddr = m_araddr_o; end
          m_rresp  = resp;
          m_rvalid = m_rready_o && (r_wait >= d1);
          if (m_rready_o) r_wait++;
          m_rdata = m_rvalid ? (slave_mem.exists(cap_araddr) ? slave_mem[cap_araddr] : '0)
                             : {$urandom, $urandom};
          if (m_rready_o && m_rvalid) r_hs = 1;
          // A request arriving while busy must be dropped, not queued.
          if (poke && m_rready_o) begin
            sri_en = 1'b1; sri_we = 1'b1; sri_addr = SAW'($urandom);
          end else begin
            sri_en = 1'b0;
          end
        end
      end
    end
    checkb("txn_timeout", done, 1'b1);
  endtask

  task automatic reset_release();
    @(negedge clk);
    rst = 1'b0;
    last_rdata = '0;
    last_err   = 1'b0;
    idle(3);
  endtask

  initial begin
    rst = 1'b1;
    sri_en = 1'b0; sri_we = 1'b0; sri_addr = '0; sri_wdata = '0; sri_be = '0;
    m_bresp = '0; m_rresp = '0; m_rdata = '0;
    slave_idle();
    for (int a = 0; a < 64; a++) begin
      model_mem[a] = {$urandom, $urandom};
      slave_mem[BASE | AW'(a)] = model_mem[a];
    end
    model_mem[6'h10] = 64'h1122_3344_5566_7788;
    slave_mem[BASE | AW'(6'h10)] = 64'h1122_3344_5566_7788;

    @(negedge clk);
    checkb("reset_ready", sri_ready_o, 1'b1);
    checkb("reset_rvalid", sri_rvalid_o, 1'b0);
    checkb("reset_error", sri_error_o, 1'b0);
    check("reset_rdata", sri_rdata_o, '0);
    checkb("reset_axi_quiet", m_awvalid_o | m_wvalid_o | m_arvalid_o | m_bready_o | m_rready_o, 1'b0);
    check("reset_state", 64'(state_dbg), 64'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Best-case write, then delayed read of a preloaded word.
    txn(1, 6'h08, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 0, 0, 0, 2'b00, 0, 0);
    idle(1);
    txn(0, 6'h10, '0, '0, 5, 3, 0, 2'b00, 0, 0);
    idle(1);
    // AW/W ordering: W first, AW first, same cycle.
    txn(1, 6'h18, 64'h0123_4567_89AB_CDEF, 8'hF0, 4, 0, 1, 2'b00, 0, 0);
    txn(1, 6'h20, 64'hFEDC_BA98_7654_3210, 8'h0F, 0, 4, 0, 2'b01, 0, 0);
    txn(1, 6'h28, 64'hA5A5_5A5A_A5A5_5A5A, 8'h3C, 2, 2, 2, 2'b00, 0, 0);
    idle(1);
    // Error responses followed by OKAY.
    txn(0, 6'h18, '0, '0, 1, 1, 0, 2'b11, 0, 0);
    txn(1, 6'h30, 64'h1111_2222_3333_4444, 8'hFF, 0, 1, 1, 2'b10, 0, 0);
    txn(0, 6'h30, '0, '0, 0, 0, 0, 2'b00, 0, 0);
    // Zero byte enables still produce a write.
    txn(1, 6'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 0, 0, 2'b00, 0, 0);
    txn(0, 6'h20, '0, '0, 0, 0, 0, 2'b00, 0, 0);
    // Request while in RD_RESP is dropped; next one is taken in the pulse cycle.
    txn(0, 6'h08, '0, '0, 0, 3, 0, 2'b00, 1, 0);
    txn(1, 6'h38, 64'h0F0F_0F0F_0F0F_0F0F, 8'hAA, 0, 0, 0, 2'b00, 0, 0);
    idle(2);

    // Reset in WR_RESP and in RD_REQ.
    txn(1, 6'h00, 64'h7777_7777_7777_7777, 8'hFF, 0, 0, 50, 2'b00, 0, 3);
    reset_release();
    txn(0, 6'h00, '0, '0, 50, 0, 0, 2'b00, 0, 2);
    reset_release();

    for (int i = 0; i < 40; i++) begin
      bit r_we;
      logic [SAW-1:0] r_addr;
      r_we   = 1'($urandom_range(0, 1));
      r_addr = {3'($urandom_range(0, 7)), 3'b000};
      txn(r_we, r_addr, {$urandom, $urandom}, BW'($urandom),
          $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
      idle($urandom_range(0, 2));
    end

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
